// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS data-memory path: bus width defaults and
// the arbiter state encoding.
package mips_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_PEND  = 2'd1,
    ARB_FORCE = 2'd2
  } arb_state_t;

  // Counter width able to hold 0..max_wait.
  function automatic int wait_cnt_width(input int max_wait);
    return $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating denial counter for the DBG port; at_limit flags that the next
// denial is the last one allowed before DBG must be forced through.
module arb_wait_counter
  import mips_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = wait_cnt_width(MAX_WAIT)
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam logic [CNT_W:0] LIMIT = (CNT_W + 1)'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt;

  assign at_limit = (({1'b0, wait_cnt} + (CNT_W + 1)'(1)) == LIMIT);

  // Holds at MAX_WAIT-1 once the limit is reached; the FSM sits in FORCE then.
  always_ff @(posedge Clk) begin
    if (Reset || clr) begin
      wait_cnt <= '0;
    end else if (inc && !at_limit) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: the CPU has fixed priority, and a bounded
// wait counter forces a one-cycle CPU stall so the debug master cannot starve.
module dmem_arbiter
  import mips_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_valid,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rd
);

  arb_state_t state;
  logic       at_limit;
  logic       wait_clr;
  logic       wait_inc;

  // DBG only beats an active CPU access once it has been forced.
  assign dbg_gnt   = dbg_req & (~cpu_req | (state == ARB_FORCE));
  assign cpu_stall = dbg_gnt & cpu_req;
  assign cpu_rdata = mem_rd;

  always_comb begin
    mem_a  = cpu_addr;
    mem_wd = cpu_wdata;
    mem_we = cpu_we & cpu_req;
    if (dbg_gnt) begin
      mem_a  = dbg_addr;
      mem_wd = dbg_wdata;
      mem_we = dbg_we;
    end
  end

  assign wait_clr = dbg_gnt | ~dbg_req;
  assign wait_inc = dbg_req & ~dbg_gnt;

  arb_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait (
    .Clk      (Clk),
    .Reset    (Reset),
    .clr      (wait_clr),
    .inc      (wait_inc),
    .at_limit (at_limit)
  );

  // Arbiter state plus the registered DBG response (read data and ack pulse).
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ARB_IDLE;
      dbg_valid <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      dbg_valid <= dbg_gnt;
      if (dbg_gnt && !dbg_we) begin
        dbg_rdata <= mem_rd;
      end
      if (wait_inc) begin
        state <= at_limit ? ARB_FORCE : ARB_PEND;
      end else begin
        state <= ARB_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed, table-driven bench for dmem_arbiter with a small behavioural data
// memory; a second instance with MAX_WAIT=1 covers the shortest forcing path.
module tb_dmem_arbiter;

  localparam logic [31:0] D = 32'hDEADBEEF;
  localparam logic [31:0] C = 32'hCAFEF00D;
  localparam logic [31:0] F = 32'h00005555;

  logic        Clk;
  logic        Reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic [31:0] cpu_rdata, dbg_rdata, mem_a, mem_wd, mem_rd;
  logic        cpu_stall, dbg_gnt, dbg_valid, mem_we;

  logic [31:0] cpu_rdata1, dbg_rdata1, mem_a1, mem_wd1, mem_rd1;
  logic        cpu_stall1, dbg_gnt1, dbg_valid1, mem_we1;

  logic [31:0] mem [0:63];

  int n_vec;
  int n_bad;

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MAX_WAIT(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_valid(dbg_valid),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MAX_WAIT(1)) dut1 (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata1), .cpu_stall(cpu_stall1),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt1), .dbg_rdata(dbg_rdata1), .dbg_valid(dbg_valid1),
    .mem_a(mem_a1), .mem_wd(mem_wd1), .mem_we(mem_we1), .mem_rd(mem_rd1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign mem_rd = mem[mem_a[7:2]];
  always @(posedge Clk) begin
    if (mem_we) mem[mem_a[7:2]] <= mem_wd;
  end

  typedef struct {
    logic        rst, chk;
    logic        creq, cwe;
    logic [31:0] caddr, cwd;
    logic        dreq, dwe;
    logic [31:0] daddr, dwd;
    logic        gnt, stall, mwe;
    logic [31:0] ma;
    logic        vld;
    logic [31:0] rdata;
    logic        chk_crd;
    logic [31:0] crd;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    input logic rst, input logic chk,
    input logic creq, input logic cwe, input logic [31:0] caddr, input logic [31:0] cwd,
    input logic dreq, input logic dwe, input logic [31:0] daddr, input logic [31:0] dwd,
    input logic gnt, input logic stall, input logic mwe, input logic [31:0] ma,
    input logic vld, input logic [31:0] rdata, input logic chk_crd, input logic [31:0] crd);
    vec_t v;
    v.rst = rst; v.chk = chk; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd;
    v.gnt = gnt; v.stall = stall; v.mwe = mwe; v.ma = ma; v.vld = vld; v.rdata = rdata;
    v.chk_crd = chk_crd; v.crd = crd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    Reset = v.rst; cpu_req = v.creq; cpu_we = v.cwe; cpu_addr = v.caddr; cpu_wdata = v.cwd;
    dbg_req = v.dreq; dbg_we = v.dwe; dbg_addr = v.daddr; dbg_wdata = v.dwd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    mem_rd1 = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    Reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

    // rst chk | creq cwe caddr cwd | dreq dwe daddr dwd | gnt stall mwe ma vld rdata | cc crd
    tv.push_back(mk(1,0, 1,0,'h00,0,    1,0,'h10,0, 0,0,0,'h00,0,0, 0,0));
    tv.push_back(mk(1,1, 1,0,'h00,0,    1,0,'h10,0, 0,0,0,'h00,0,0, 0,0));
    tv.push_back(mk(0,1, 1,0,'h00,0,    1,0,'h10,0, 0,0,0,'h00,0,0, 0,0));
    tv.push_back(mk(0,1, 0,0,'h00,0,    0,0,'h10,0, 0,0,0,'h00,0,0, 0,0));
    tv.push_back(mk(0,1, 0,0,'h00,0,    1,1,'h10,D, 1,0,1,'h10,0,0, 0,0));
    tv.push_back(mk(0,1, 0,0,'h00,0,    1,0,'h10,0, 1,0,0,'h10,1,0, 1,D));
    tv.push_back(mk(0,1, 0,0,'h00,0,    0,0,'h10,0, 0,0,0,'h00,1,D, 0,0));
    tv.push_back(mk(0,1, 0,0,'h00,0,    0,0,'h10,0, 0,0,0,'h00,0,D, 0,0));
    for (int i = 0; i < 4; i++)
      tv.push_back(mk(0,1, 1,1,'h40,F,  1,0,'h10,0, 0,0,1,'h40,0,D, 0,0));
    tv.push_back(mk(0,1, 1,1,'h40,F,    1,0,'h10,0, 1,1,0,'h10,0,D, 1,D));
    tv.push_back(mk(0,1, 1,0,'h40,0,    0,0,'h10,0, 0,0,0,'h40,1,D, 1,F));
    tv.push_back(mk(0,1, 1,1,'h20,'h1234, 1,1,'h20,C, 0,0,1,'h20,0,D, 0,0));
    tv.push_back(mk(0,1, 0,0,'h20,0,    1,1,'h20,C, 1,0,1,'h20,0,D, 1,'h1234));
    tv.push_back(mk(0,1, 1,0,'h20,0,    0,0,'h20,0, 0,0,0,'h20,1,D, 1,C));
    tv.push_back(mk(0,1, 1,0,'h20,0,    1,0,'h40,0, 0,0,0,'h20,0,D, 0,0));
    tv.push_back(mk(0,1, 1,0,'h20,0,    1,0,'h40,0, 0,0,0,'h20,0,D, 0,0));
    tv.push_back(mk(0,1, 1,0,'h20,0,    0,0,'h40,0, 0,0,0,'h20,0,D, 0,0));
    for (int i = 0; i < 4; i++)
      tv.push_back(mk(0,1, 1,0,'h20,0,  1,0,'h40,0, 0,0,0,'h20,0,D, 0,0));
    tv.push_back(mk(0,1, 1,0,'h20,0,    1,0,'h40,0, 1,1,0,'h40,0,D, 0,0));
    tv.push_back(mk(0,1, 0,0,'h20,0,    0,0,'h40,0, 0,0,0,'h20,1,F, 1,C));
    tv.push_back(mk(0,1, 0,0,'h20,0,    1,0,'h20,0, 1,0,0,'h20,0,F, 0,0));
    tv.push_back(mk(0,1, 0,0,'h20,0,    1,0,'h10,0, 1,0,0,'h10,1,C, 0,0));
    tv.push_back(mk(0,1, 0,0,'h20,0,    0,0,'h10,0, 0,0,0,'h20,1,D, 0,0));
    for (int i = 0; i < 3; i++)
      tv.push_back(mk(0,1, 1,0,'h20,0,  1,0,'h10,0, 0,0,0,'h20,0,D, 0,0));
    tv.push_back(mk(1,1, 1,0,'h20,0,    1,0,'h10,0, 0,0,0,'h20,0,D, 0,0));
    for (int i = 0; i < 4; i++)
      tv.push_back(mk(0,1, 1,0,'h20,0,  1,0,'h10,0, 0,0,0,'h20,0,0, 0,0));
    tv.push_back(mk(0,1, 1,0,'h20,0,    1,0,'h10,0, 1,1,0,'h10,0,0, 0,0));
    tv.push_back(mk(0,1, 1,0,'h20,0,    0,0,'h10,0, 0,0,0,'h20,1,D, 0,0));

    foreach (tv[i]) begin
      @(posedge Clk);
      #1;
      drive(tv[i]);
      @(negedge Clk);
      if (tv[i].chk) begin
        check($sformatf("v%0d dbg_gnt", i),   {31'b0, dbg_gnt},   {31'b0, tv[i].gnt});
        check($sformatf("v%0d cpu_stall", i), {31'b0, cpu_stall}, {31'b0, tv[i].stall});
        check($sformatf("v%0d mem_we", i),    {31'b0, mem_we},    {31'b0, tv[i].mwe});
        check($sformatf("v%0d mem_a", i),     mem_a,              tv[i].ma);
        check($sformatf("v%0d dbg_valid", i), {31'b0, dbg_valid}, {31'b0, tv[i].vld});
        check($sformatf("v%0d dbg_rdata", i), dbg_rdata,          tv[i].rdata);
        if (tv[i].chk_crd)
          check($sformatf("v%0d cpu_rdata", i), cpu_rdata, tv[i].crd);
      end
    end

    // MAX_WAIT=1: one denied cycle, then DBG is forced through with a stall.
    @(posedge Clk);
    #1;
    Reset = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'h77;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10;
    @(negedge Clk);
    check("mw1 first gnt", {31'b0, dbg_gnt1}, 32'd0);
    check("mw1 first mem_we", {31'b0, mem_we1}, 32'd1);
    check("mw4 first gnt", {31'b0, dbg_gnt}, 32'd0);
    @(posedge Clk);
    #1;
    @(negedge Clk);
    check("mw1 forced gnt", {31'b0, dbg_gnt1}, 32'd1);
    check("mw1 forced stall", {31'b0, cpu_stall1}, 32'd1);
    check("mw1 forced mem_a", mem_a1, 32'h10);
    check("mw1 forced mem_we", {31'b0, mem_we1}, 32'd0);
    check("mw4 second gnt", {31'b0, dbg_gnt}, 32'd0);
    @(posedge Clk);
    #1;
    dbg_req = 1'b0; cpu_we = 1'b0;
    @(negedge Clk);
    check("mw1 valid", {31'b0, dbg_valid1}, 32'd1);
    check("mw1 rdata", dbg_rdata1, 32'h0);
    check("mw1 cpu_rdata", cpu_rdata1, 32'h0);
    check("mw1 stall released", {31'b0, cpu_stall1}, 32'd0);
    check("mw4 no valid", {31'b0, dbg_valid}, 32'd0);
    check("mw4 mem_wd", mem_wd, 32'h77);
    check("mw1 mem_wd", mem_wd1, 32'h77);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the single-cycle MIPS core (CPU port) and a debug/loader master (DBG port).
- Sits between the processor's memory outputs and the data memory unit, inside the top-level view.
- The CPU has fixed priority. A wait counter bounds DBG starvation by forcing a one-cycle CPU stall.
- Stall semantics: the core must not update PC or the register file during a stall.

Parameters:
- DATA_W, 32, data bus width
- ADDR_W, 32, address bus width
- MAX_WAIT, 4, cycles a DBG request may be denied before it is forced (legal 1..255)

Ports:
- Clk  in  1  system clock
- Reset  in  1  reset
- cpu_req  in  1  CPU accesses memory this cycle (load or store)
- cpu_we  in  1  CPU store (MemWrite)
- cpu_addr  in  ADDR_W  CPU address (ALUOut)
- cpu_wdata  in  DATA_W  CPU store data
- cpu_rdata  out  DATA_W  CPU load data (combinational)
- cpu_stall  out  1  freeze core this cycle
- dbg_req  in  1  DBG request; held until granted
- dbg_we  in  1  DBG write
- dbg_addr  in  ADDR_W  DBG address
- dbg_wdata  in  DATA_W  DBG write data
- dbg_gnt  out  1  DBG owns memory this cycle (combinational)
- dbg_rdata  out  DATA_W  registered DBG read data
- dbg_valid  out  1  one-cycle pulse the cycle after any DBG grant
- mem_a  out  ADDR_W  memory address
- mem_wd  out  DATA_W  memory write data
- mem_we  out  1  memory write enable
- mem_rd  in  DATA_W  memory read data (asynchronous read)

Interface (already decided):
- One clock, Clk.
- Reset is synchronous and active-high, named Reset; it is sampled only on the rising edge of Clk.

Behaviour:
- States:
  - IDLE: no DBG request pending.
  - PEND: DBG request is being denied.
  - FORCE: DBG wins the next cycle unconditionally.
- Registers: state, wait_cnt (width clog2(MAX_WAIT+1)), dbg_rdata, dbg_valid.
- Grant, combinational: dbg_gnt = dbg_req & (~cpu_req | state==FORCE).
- Stall, combinational: cpu_stall = dbg_gnt & cpu_req; this is only possible in FORCE.
- Mux:
  - When dbg_gnt: mem_a/mem_wd/mem_we come from the dbg_* inputs.
  - Otherwise: mem_a=cpu_addr, mem_wd=cpu_wdata, mem_we=cpu_we & cpu_req.
- Address gating: the non-granted requester never drives mem_we; when cpu_stall=1, mem_we is dbg_we.
- cpu_rdata = mem_rd at all times. The CPU ignores it while stalled.
- DBG read: on a dbg_gnt cycle with dbg_we=0, dbg_rdata <= mem_rd at the edge. dbg_valid=1 for exactly the next cycle.
- DBG write: dbg_valid also pulses the next cycle as the write acknowledge; dbg_rdata is unchanged.
- Transitions (evaluated each edge):
  - dbg_gnt: state->IDLE, wait_cnt->0.
  - dbg_req & ~dbg_gnt, wait_cnt+1 == MAX_WAIT: state->FORCE, wait_cnt held.
  - dbg_req & ~dbg_gnt, otherwise: state->PEND, wait_cnt+1.
  - ~dbg_req: state->IDLE, wait_cnt->0. A withdrawn request is legal; its pending credit is discarded.
- Boundaries:
  - MAX_WAIT=1: the first denied cycle moves to FORCE, so DBG latency is at most 2 cycles.
  - Back-to-back DBG requests: a new request right after a grant may be granted immediately if the CPU is idle. It restarts the count from 0 otherwise.
  - Simultaneous CPU and DBG requests in IDLE or PEND: the CPU wins with no stall.
- Reset outputs: state=IDLE, wait_cnt=0, dbg_valid=0, dbg_rdata=0. The combinational outputs follow their inputs.
- Reset mid-operation: a pending or forced request is dropped and no dbg_valid is emitted. A DBG request held through Reset is re-arbitrated from IDLE.
- Latency:
  - CPU: 0 cycles (same-cycle access, as the single-cycle core requires).
  - DBG: at most MAX_WAIT+1 cycles from first assertion to grant, data/valid 1 cycle later.

Decomposition:
- Shared package mips_pkg holds:
  - state enum arb_state_t {ARB_IDLE, ARB_PEND, ARB_FORCE}
  - DATA_W/ADDR_W defaults
- One sub-module, arb_wait_counter: a saturating counter with clear/increment inputs that outputs a limit-reached flag.
- The mux and FSM stay in dmem_arbiter.

Test Plan:
- Reset asserted 2 cycles with both requests high -> dbg_valid=0, dbg_rdata=0. The first cycle after reset grants the CPU (cpu_req=1), and dbg_gnt=0.
- CPU idle; DBG write addr 0x10 data 0xDEADBEEF -> dbg_gnt=1 same cycle, mem_we=1, mem_a=0x10, dbg_valid pulse next cycle. A following DBG read of 0x10 -> dbg_rdata=0xDEADBEEF with dbg_valid.
- cpu_req held high continuously, DBG read requested, MAX_WAIT=4 -> dbg_gnt=0 for 4 cycles. Cycle 5: dbg_gnt=1, cpu_stall=1, and the CPU's mem_we is suppressed. Cycle 6: dbg_valid=1, cpu_stall=0.
- CPU store (cpu_we=1, addr 0x20, data 0x1234) and DBG write to 0x20 in the same IDLE cycle -> the CPU write lands, cpu_stall=0, DBG pending. Memory finally holds the DBG data after the DBG grant.
- DBG request in PEND with wait_cnt=3, then Reset for 1 cycle -> state IDLE, wait_cnt 0, no dbg_valid. The full MAX_WAIT count restarts afterwards.
- DBG request withdrawn after 2 denied cycles, then re-asserted -> the count restarts at 0, with no grant before 4 further denied cycles.
